// File: rtl/chol_result_collector_if.sv
`default_nettype none
// ============================================================================
// Module   : chol_result_collector_if
// Brief    : Handshake/bus bundle between the Cholesky factor producer, the
//            result collector and its downstream reader.
// Revision : 1.0 - initial release
// ============================================================================
interface chol_result_collector_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
);
    logic              start;
    logic [3:0]        matrix_size;
    logic              in_valid;
    logic [DATA_W-1:0] diag_in;
    logic [DATA_W-1:0] lower_in;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] beat_count;
    logic              err;

    // Producer / reader side
    modport master (
        output start, matrix_size, in_valid, diag_in, lower_in, rd_en, rd_addr,
        input  rd_data, rd_valid, busy, done, beat_count, err
    );

    // Collector side
    modport slave (
        input  start, matrix_size, in_valid, diag_in, lower_in, rd_en, rd_addr,
        output rd_data, rd_valid, busy, done, beat_count, err
    );
endinterface
`default_nettype wire

// File: rtl/chol_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : chol_result_collector
// Brief    : Captures a streamed lower-triangular Cholesky factor into a
//            packed column-major buffer and serves it through a registered
//            read port. Flags protocol misuse with a sticky error.
// Revision : 1.0 - initial release
// ============================================================================
module chol_result_collector #(
    parameter int DATA_W = 32,
    parameter int MAX_N  = 12,
    parameter int ADDR_W = 7
) (
    input  wire logic               clock,
    input  wire logic               reset,
    chol_result_collector_if.slave  bus
);

    localparam logic [3:0] c_MAX_N = 4'(MAX_N);
    localparam int         c_DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_n;
    logic [3:0]        r_col;
    logic [3:0]        r_k;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_beat_count;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic              w_size_ok;
    logic              w_col_end;
    logic              w_final;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_wr_data;

    // Start is legal only for 1..MAX_N; column j holds N-j beats, the
    // last column (j=N-1) holds just its diagonal element.
    assign w_size_ok = (bus.matrix_size != 4'd0) && (bus.matrix_size <= c_MAX_N);
    assign w_col_end = (r_k == (r_n - 4'd1 - r_col));
    assign w_final   = w_col_end && (r_col == (r_n - 4'd1));
    assign w_wr_en   = (r_state == ST_COLLECT) && bus.in_valid;
    assign w_wr_data = (r_k == 4'd0) ? bus.diag_in : bus.lower_in;

    // Control FSM: arming, beat bookkeeping, completion pulse and sticky error.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_n          <= 4'd0;
            r_col        <= 4'd0;
            r_k          <= 4'd0;
            r_wr_ptr     <= '0;
            r_beat_count <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        if (w_size_ok) begin
                            r_state      <= ST_COLLECT;
                            r_n          <= bus.matrix_size;
                            r_col        <= 4'd0;
                            r_k          <= 4'd0;
                            r_wr_ptr     <= '0;
                            r_beat_count <= '0;
                            r_err        <= 1'b0;
                            r_busy       <= 1'b1;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end else if (bus.in_valid) begin
                        // Beat outside a collection window is dropped.
                        r_err <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (bus.start) begin
                        r_err <= 1'b1;
                    end
                    if (bus.in_valid) begin
                        r_wr_ptr     <= r_wr_ptr + 1'b1;
                        r_beat_count <= r_beat_count + 1'b1;
                        if (w_col_end) begin
                            r_k   <= 4'd0;
                            r_col <= r_col + 4'd1;
                        end else begin
                            r_k <= r_k + 4'd1;
                        end
                        if (w_final) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Buffer write port; contents intentionally survive reset.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    // Registered read port; addresses not yet written in this run read as 0,
    // which also hides stale data after a reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (bus.rd_en && (r_state != ST_COLLECT)) begin
            r_rd_valid <= 1'b1;
            r_rd_data  <= (bus.rd_addr < r_beat_count) ? r_mem[bus.rd_addr] : '0;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end
    end

    assign bus.rd_data    = r_rd_data;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.beat_count = r_beat_count;
    assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_chol_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_chol_result_collector
// Brief    : Directed self-checking bench for chol_result_collector with a
//            read-response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chol_result_collector;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rd_exp_t;

    rd_exp_t sb_q[$];

    chol_result_collector_if #(.DATA_W(32), .ADDR_W(7)) bus ();

    chol_result_collector #(
        .DATA_W(32),
        .MAX_N (12),
        .ADDR_W(7)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic [31:0] l);
        bus.in_valid = 1'b1;
        bus.diag_in  = d;
        bus.lower_in = l;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic rd(input logic [6:0] addr, input logic [31:0] exp);
        rd_exp_t e;
        e.data = exp;
        e.cyc  = cyc;
        sb_q.push_back(e);
        bus.rd_en   = 1'b1;
        bus.rd_addr = addr;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] n);
        bus.start       = 1'b1;
        bus.matrix_size = n;
        tick();
        bus.start = 1'b0;
    endtask

    // Read-response monitor: every rd_valid must match the oldest request,
    // arriving exactly one cycle after it was issued.
    always @(negedge clk) begin
        rd_exp_t e;
        if (bus.rd_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: got rd_valid=1 data %h expected no response (cycle %0d)",
                         bus.rd_data, cyc);
            end else begin
                e = sb_q.pop_front();
                chk("rd_data", bus.rd_data, e.data);
                chk("rd_latency", 32'(cyc), 32'(e.cyc + 1));
            end
        end
    end

    initial begin
        logic [31:0] exp_w;
        cyc             = 0;
        n_checks        = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.matrix_size = 4'd0;
        bus.in_valid    = 1'b0;
        bus.diag_in     = '0;
        bus.lower_in    = '0;
        bus.rd_en       = 1'b0;
        bus.rd_addr     = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_beat_count", bus.beat_count, 0);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        rst_n = 1'b1;
        tick();

        // Illegal sizes leave the block idle with err raised
        do_start(4'd0);
        chk("t4_err_n0", bus.err, 1);
        chk("t4_busy_n0", bus.busy, 0);
        do_start(4'd13);
        chk("t4_err_n13", bus.err, 1);
        chk("t4_busy_n13", bus.busy, 0);
        rd(7'd0, 32'h0);

        // Legal N=1 start clears err; single beat finishes the run
        do_start(4'd1);
        chk("t4_err_cleared", bus.err, 0);
        chk("t3_busy", bus.busy, 1);
        beat(32'h3f800000, 32'hdeadbeef);
        chk("t3_done", bus.done, 1);
        chk("t3_busy_low", bus.busy, 0);
        chk("t3_beat_count", bus.beat_count, 1);
        tick();
        chk("t3_done_drop", bus.done, 0);
        rd(7'd0, 32'h3f800000);
        rd(7'd1, 32'h0);

        // N=4 back-to-back: diagonals land at packed 0,4,7,9
        do_start(4'd4);
        for (int i = 0; i < 10; i++) begin
            beat(32'h40000000, 32'h3f800000);
            if (i < 9) chk("t1_done_early", bus.done, 0);
        end
        chk("t1_done", bus.done, 1);
        chk("t1_beat_count", bus.beat_count, 10);
        tick();
        chk("t1_done_once", bus.done, 0);
        for (int a = 0; a < 10; a++) begin
            exp_w = (a == 0 || a == 4 || a == 7 || a == 9) ? 32'h40000000 : 32'h3f800000;
            rd(7'(a), exp_w);
        end

        // Stray beat in DONE: dropped, err set, buffer untouched
        beat(32'hdeadbeef, 32'hdeadbeef);
        chk("t6_err_done_beat", bus.err, 1);
        chk("t6_beat_count_held", bus.beat_count, 10);
        for (int a = 0; a < 10; a++) begin
            exp_w = (a == 0 || a == 4 || a == 7 || a == 9) ? 32'h40000000 : 32'h3f800000;
            rd(7'(a), exp_w);
        end

        // Start during COLLECT is ignored (err set), N=3 run still completes
        do_start(4'd3);
        chk("t6_err_cleared", bus.err, 0);
        beat(32'ha0000000, 32'hb0000000);
        beat(32'ha0000001, 32'hb0000001);
        do_start(4'd5);
        chk("t6_err_collect_start", bus.err, 1);
        chk("t6_busy_kept", bus.busy, 1);
        for (int i = 2; i < 6; i++) beat(32'ha0000000 | 32'(i), 32'hb0000000 | 32'(i));
        chk("t6_done", bus.done, 1);
        chk("t6_beat_count", bus.beat_count, 6);
        tick();
        for (int a = 0; a < 6; a++) begin
            exp_w = (a == 0 || a == 3 || a == 5) ? (32'ha0000000 | 32'(a)) : (32'hb0000000 | 32'(a));
            rd(7'(a), exp_w);
        end

        // N=12 with random gaps; one read attempted mid-collect must be ignored
        do_start(4'd12);
        for (int i = 0; i < 78; i++) begin
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("t2_no_done_gap", bus.done, 0);
            end
            if (i == 20) begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = 7'd3;
                tick();
                bus.rd_en = 1'b0;
            end
            beat(32'(i), 32'(i));
        end
        chk("t2_done", bus.done, 1);
        chk("t2_beat_count", bus.beat_count, 78);
        tick();
        for (int a = 0; a < 78; a++) rd(7'(a), 32'(a));
        rd(7'd78, 32'h0);

        // Reset mid-collect wipes visibility of partial data
        do_start(4'd4);
        for (int i = 0; i < 5; i++) beat(32'h11110000 | 32'(i), 32'h22220000 | 32'(i));
        do_start(4'd4);
        chk("t5_err_pre", bus.err, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_busy", bus.busy, 0);
        chk("t5_err", bus.err, 0);
        chk("t5_beat_count", bus.beat_count, 0);
        chk("t5_done", bus.done, 0);
        chk("t5_rd_valid", bus.rd_valid, 0);
        chk("t5_rd_data", bus.rd_data, 0);
        tick();
        rst_n = 1'b1;
        tick();
        rd(7'd2, 32'h0);
        do_start(4'd4);
        for (int i = 0; i < 10; i++) beat(32'hc0000000 | 32'(i), 32'hd0000000 | 32'(i));
        chk("t5_done_rerun", bus.done, 1);
        chk("t5_beat_count_rerun", bus.beat_count, 10);
        tick();
        for (int a = 0; a < 10; a++) begin
            exp_w = (a == 0 || a == 4 || a == 7 || a == 9) ? (32'hc0000000 | 32'(a)) : (32'hd0000000 | 32'(a));
            rd(7'(a), exp_w);
        end

        repeat (3) tick();
        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
